// File: rtl/gate_array_pipe.sv
// WIDTH-channel registered 2-input logic array with valid/ready handshake and saturating
// transfer counter. Optional even-parity output enabled by defining GATE_ARRAY_PARITY_EN.
module gate_array_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op_sel,
    input  logic             op_load,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       op_cur,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef GATE_ARRAY_PARITY_EN
    ,
    output logic             out_par
`endif
);

    typedef enum logic [2:0] {
        OP_NAND = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_BUFA = 3'd7
    } op_e;

    op_e              op_cur_q, op_cur_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [WIDTH-1:0] f_res;
    logic             accept, take;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        f_res = '0;
        unique case (op_cur_q)
            OP_NAND: f_res = ~(in_a & in_b);
            OP_AND:  f_res = in_a & in_b;
            OP_OR:   f_res = in_a | in_b;
            OP_NOR:  f_res = ~(in_a | in_b);
            OP_XOR:  f_res = in_a ^ in_b;
            OP_XNOR: f_res = ~(in_a ^ in_b);
            OP_NOTA: f_res = ~in_a;
            OP_BUFA: f_res = in_a;
            default: f_res = '0;
        endcase
    end

    // Ready depends only on the held result and downstream, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;

    always_comb begin
        op_cur_d    = op_load ? op_e'(op_sel) : op_cur_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_y_d     = f_res;
            out_valid_d = 1'b1;
        end else if (take) begin
            out_valid_d = 1'b0;
        end
        xfer_cnt_d = (take && (xfer_cnt_q != '1)) ? xfer_cnt_q + CNT_W'(1) : xfer_cnt_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update
        // together from pre-edge values, independent of statement order.
        if (rst) begin
            op_cur_q    <= OP_NAND;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            op_cur_q    <= op_cur_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign op_cur    = op_cur_q;
    assign xfer_cnt  = xfer_cnt_q;

`ifdef GATE_ARRAY_PARITY_EN
    logic out_par_q, out_par_d;

    // Parity follows out_y exactly: loaded on accept, held otherwise.
    assign out_par_d = accept ? ^f_res : out_par_q;

    always_ff @(posedge clk) begin
        if (rst) out_par_q <= 1'b0;
        else     out_par_q <= out_par_d;
    end

    assign out_par = out_par_q;
`endif

endmodule
